// File: rtl/uart_flex.sv
// UART with runtime baud divisor, 1/2 stop bits and TX/RX FWFT FIFOs.
// Optional parity support is enabled by defining UART_FLEX_PARITY_EN.
module uart_flex #(
    parameter int DATA_BITS = 8,
    parameter int FIFO_W    = 2,
    parameter int DIV_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] divisor,
    input  logic             stop2,
`ifdef UART_FLEX_PARITY_EN
    input  logic             par_en,
    input  logic             par_odd,
`endif
    input  logic             rx,
    output logic             tx,
    input  logic             wr_uart,
    input  logic [7:0]       w_data,
    input  logic             rd_uart,
    output logic [7:0]       rd_data,
    output logic             tx_full,
    output logic             tx_empty,
    output logic             rx_full,
    output logic             rx_empty,
    output logic             frame_err,
    output logic             parity_err,
    output logic             overrun_err,
    input  logic             err_clr,
    output logic             tx_busy
);

    localparam int DEPTH = 2 ** FIFO_W;
    localparam logic [FIFO_W:0] FULL_CNT = (FIFO_W + 1)'(DEPTH);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_FLEX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    logic [DIV_W-1:0] r_baud;
    logic             w_tick;

    assign w_tick = (r_baud == '0);

    always_ff @(posedge clk) begin
        if (reset) r_baud <= '0;
        else if (w_tick) r_baud <= divisor;
        else r_baud <= r_baud - DIV_W'(1);
    end

    logic [7:0]        r_txf_mem [DEPTH];
    logic [FIFO_W-1:0] r_txf_wp, r_txf_rp;
    logic [FIFO_W:0]   r_txf_cnt;
    logic              w_txf_push, w_txf_pop;
    logic [7:0]        w_txf_head;

    assign tx_full    = (r_txf_cnt == FULL_CNT);
    assign tx_empty   = (r_txf_cnt == '0);
    assign w_txf_push = wr_uart && (!tx_full || w_txf_pop);
    assign w_txf_head = r_txf_mem[r_txf_rp];

    always_ff @(posedge clk) begin
        if (w_txf_push) r_txf_mem[r_txf_wp] <= 8'(w_data[DATA_BITS-1:0]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_txf_wp  <= '0;
            r_txf_rp  <= '0;
            r_txf_cnt <= '0;
        end else begin
            if (w_txf_push) r_txf_wp <= r_txf_wp + FIFO_W'(1);
            if (w_txf_pop) r_txf_rp <= r_txf_rp + FIFO_W'(1);
            r_txf_cnt <= r_txf_cnt + (FIFO_W + 1)'(w_txf_push)
                                   - (FIFO_W + 1)'(w_txf_pop);
        end
    end

    logic [7:0]        r_rxf_mem [DEPTH];
    logic [FIFO_W-1:0] r_rxf_wp, r_rxf_rp;
    logic [FIFO_W:0]   r_rxf_cnt;
    logic              w_rxf_push, w_rxf_pop;
    logic              w_rx_push_req;
    logic [DATA_BITS-1:0] r_rx_sh;

    assign rx_full    = (r_rxf_cnt == FULL_CNT);
    assign rx_empty   = (r_rxf_cnt == '0);
    assign w_rxf_pop  = rd_uart && !rx_empty;
    assign w_rxf_push = w_rx_push_req && (!rx_full || w_rxf_pop);
    assign rd_data    = rx_empty ? 8'h00 : r_rxf_mem[r_rxf_rp];

    always_ff @(posedge clk) begin
        if (w_rxf_push) r_rxf_mem[r_rxf_wp] <= 8'(r_rx_sh);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rxf_wp  <= '0;
            r_rxf_rp  <= '0;
            r_rxf_cnt <= '0;
        end else begin
            if (w_rxf_push) r_rxf_wp <= r_rxf_wp + FIFO_W'(1);
            if (w_rxf_pop) r_rxf_rp <= r_rxf_rp + FIFO_W'(1);
            r_rxf_cnt <= r_rxf_cnt + (FIFO_W + 1)'(w_rxf_push)
                                   - (FIFO_W + 1)'(w_rxf_pop);
        end
    end

    state_t     r_tx_state, w_tx_next;
    logic [3:0] r_tx_tcnt;
    logic [2:0] r_tx_idx;
    logic [7:0] r_tx_sh;
    logic       r_tx_stop2;
    logic       w_tx_bit_end;
    logic       w_tx;
`ifdef UART_FLEX_PARITY_EN
    logic       r_tx_par_en;
    logic       r_tx_par;
`endif

    assign w_tx_bit_end = w_tick && (r_tx_tcnt == 4'd15);
    assign tx           = w_tx;
    assign tx_busy      = (r_tx_state != S_IDLE);

    always_comb begin
        w_tx_next = r_tx_state;
        w_txf_pop = 1'b0;
        w_tx      = 1'b1;
        unique case (r_tx_state)
            S_IDLE: begin
                if (!tx_empty) begin
                    w_txf_pop = 1'b1;
                    w_tx_next = S_START;
                end
            end
            S_START: begin
                w_tx = 1'b0;
                if (w_tx_bit_end) w_tx_next = S_DATA;
            end
            S_DATA: begin
                w_tx = r_tx_sh[0];
                if (w_tx_bit_end && r_tx_idx == LAST_BIT) begin
`ifdef UART_FLEX_PARITY_EN
                    w_tx_next = r_tx_par_en ? S_PARITY : S_STOP;
`else
                    w_tx_next = S_STOP;
`endif
                end
            end
`ifdef UART_FLEX_PARITY_EN
            S_PARITY: begin
                w_tx = r_tx_par;
                if (w_tx_bit_end) w_tx_next = S_STOP;
            end
`endif
            S_STOP: begin
                if (w_tx_bit_end && (!r_tx_stop2 || r_tx_idx == 3'd1))
                    w_tx_next = S_IDLE;
            end
            default: w_tx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_state <= S_IDLE;
            r_tx_tcnt  <= '0;
            r_tx_idx   <= '0;
            r_tx_sh    <= '0;
            r_tx_stop2 <= 1'b0;
`ifdef UART_FLEX_PARITY_EN
            r_tx_par_en <= 1'b0;
            r_tx_par    <= 1'b0;
`endif
        end else begin
            r_tx_state <= w_tx_next;
            if (w_txf_pop) begin
                r_tx_sh    <= w_txf_head;
                r_tx_stop2 <= stop2;
                r_tx_tcnt  <= '0;
                r_tx_idx   <= '0;
`ifdef UART_FLEX_PARITY_EN
                r_tx_par_en <= par_en;
                r_tx_par    <= (^w_txf_head[DATA_BITS-1:0]) ^ par_odd;
`endif
            end else if (r_tx_state != S_IDLE && w_tick) begin
                r_tx_tcnt <= r_tx_tcnt + 4'd1;
                if (w_tx_bit_end) begin
                    r_tx_idx <= (w_tx_next != r_tx_state) ? 3'd0
                                                          : r_tx_idx + 3'd1;
                    if (r_tx_state == S_DATA) r_tx_sh <= {1'b0, r_tx_sh[7:1]};
                end
            end
        end
    end

    state_t     r_rx_state, w_rx_next;
    logic [3:0] r_rx_tcnt;
    logic [2:0] r_rx_idx;
    logic       r_rx_prev;
    logic       w_rx_samp;
    logic       w_ferr_set, w_ovr_set, w_perr_set;

    assign w_rx_samp = w_tick && (r_rx_tcnt == 4'd15);
    assign w_ovr_set = w_rx_push_req && rx_full && !w_rxf_pop;

    always_comb begin
        w_rx_next     = r_rx_state;
        w_rx_push_req = 1'b0;
        w_ferr_set    = 1'b0;
        w_perr_set    = 1'b0;
        unique case (r_rx_state)
            S_IDLE: begin
                if (r_rx_prev && !rx) w_rx_next = S_START;
            end
            // mid-start re-check rejects short low glitches
            S_START: begin
                if (w_tick && r_rx_tcnt == 4'd7)
                    w_rx_next = rx ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (w_rx_samp && r_rx_idx == LAST_BIT) begin
`ifdef UART_FLEX_PARITY_EN
                    w_rx_next = par_en ? S_PARITY : S_STOP;
`else
                    w_rx_next = S_STOP;
`endif
                end
            end
`ifdef UART_FLEX_PARITY_EN
            S_PARITY: begin
                if (w_rx_samp) begin
                    w_rx_next  = S_STOP;
                    w_perr_set = rx != ((^r_rx_sh) ^ par_odd);
                end
            end
`endif
            S_STOP: begin
                if (w_rx_samp) begin
                    w_rx_next     = S_IDLE;
                    w_rx_push_req = rx;
                    w_ferr_set    = !rx;
                end
            end
            default: w_rx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_state <= S_IDLE;
            r_rx_tcnt  <= '0;
            r_rx_idx   <= '0;
            r_rx_sh    <= '0;
            r_rx_prev  <= 1'b1;
        end else begin
            r_rx_prev  <= rx;
            r_rx_state <= w_rx_next;
            if (r_rx_state == S_IDLE) begin
                r_rx_tcnt <= '0;
                r_rx_idx  <= '0;
            end else if (w_tick) begin
                r_rx_tcnt <= (w_rx_next != r_rx_state) ? 4'd0
                                                       : r_rx_tcnt + 4'd1;
                if (w_rx_next != r_rx_state) r_rx_idx <= '0;
                else if (w_rx_samp) r_rx_idx <= r_rx_idx + 3'd1;
                if (r_rx_state == S_DATA && w_rx_samp)
                    r_rx_sh <= {rx, r_rx_sh[DATA_BITS-1:1]};
            end
        end
    end

    logic r_ferr, r_ovr;

    assign frame_err   = r_ferr;
    assign overrun_err = r_ovr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ferr <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            r_ferr <= w_ferr_set | (r_ferr & ~err_clr);
            r_ovr  <= w_ovr_set | (r_ovr & ~err_clr);
        end
    end

`ifdef UART_FLEX_PARITY_EN
    logic r_perr;

    assign parity_err = r_perr;

    always_ff @(posedge clk) begin
        if (reset) r_perr <= 1'b0;
        else r_perr <= w_perr_set | (r_perr & ~err_clr);
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule
